// File: rtl/mips_pkg.sv
// Shared widths and types for the writeback path: register/data widths,
// the buffered port-B entry format and the arbiter's per-cycle source select.
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  regAddr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_B
  } wb_sel_e;

  // A write to $0 never creates a hazard, so it is excluded here once.
  function automatic logic regHit(input logic [REG_W-1:0] src,
                                  input logic [REG_W-1:0] dst,
                                  input logic             dstValid);
    return dstValid && (src == dst) && (src != ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for port-B results; exposes per-entry destination
// registers and valid bits so the arbiter can flag pending writes.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_i,
  input  wb_entry_t                       pushEntry_i,
  input  logic                            pop_i,
  output wb_entry_t                       headEntry_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic [DEPTH-1:0][REG_W-1:0]     entryRegs_o,
  output logic [DEPTH-1:0]                entryValid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [PTR_W-1:0]            wrPtr_q;
  logic [PTR_W-1:0]            rdPtr_q;
  logic [PTR_W:0]              count_q;
  wb_entry_t [DEPTH-1:0]       mem_q;
  logic [DEPTH-1:0]            valid_q;
  logic                        pushEn;
  logic                        popEn;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign pushEn  = push_i && !full_o;
  assign popEn   = pop_i && !empty_o;

  assign headEntry_o  = mem_q[rdPtr_q];
  assign entryValid_o = valid_q;

  always_comb begin
    entryRegs_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryRegs_o[i] = mem_q[i].regAddr;
    end
  end

  // Push and pop can only hit the same slot when empty or full, and the
  // gating above rules both of those out, so the valid bit updates never clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (pushEn) begin
        mem_q[wrPtr_q]   <= pushEntry_i;
        valid_q[wrPtr_q] <= 1'b1;
        wrPtr_q          <= wrPtr_q + 1'b1;
      end
      if (popEn) begin
        valid_q[rdPtr_q] <= 1'b0;
        rdPtr_q          <= rdPtr_q + 1'b1;
      end
      case ({pushEn, popEn})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU results (port A) win by default,
// buffered multi-cycle results (port B) drain when A is idle or when starved.
module wb_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_W-1:0]  b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              a_hold,
  output logic              err,
  input  logic [REG_W-1:0]  readReg1,
  input  logic [REG_W-1:0]  readReg2,
  output logic              pend1,
  output logic              pend2,
  output logic              RegWriteSig,
  output logic [REG_W-1:0]  writeReg,
  output logic [DATA_W-1:0] writeData
);

  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    FULL_COUNT   = DEPTH[CNT_W-1:0];
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_MAX[STARVE_W-1:0];

  logic                         fifoPush;
  logic                         fifoPop;
  logic                         fifoFull;
  logic                         fifoEmpty;
  logic [CNT_W-1:0]             fifoCount;
  wb_entry_t                    fifoHead;
  logic [DEPTH-1:0][REG_W-1:0]  fifoRegs;
  logic [DEPTH-1:0]             fifoValid;

  wb_sel_e                      sel;
  logic [STARVE_W-1:0]          starve_q, starve_d;
  logic                         aHold_q, aHold_d;
  logic                         err_q, err_d;
  logic                         we_q, we_d;
  logic [REG_W-1:0]             reg_q, reg_d;
  logic [DATA_W-1:0]            data_q, data_d;

  assign b_ready  = (fifoCount != FULL_COUNT);
  assign fifoPush = b_valid && !fifoFull;
  assign fifoPop  = (sel == SEL_B);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (fifoPush),
    .pushEntry_i  ('{regAddr: b_reg, data: b_data}),
    .pop_i        (fifoPop),
    .headEntry_o  (fifoHead),
    .full_o       (fifoFull),
    .empty_o      (fifoEmpty),
    .count_o      (fifoCount),
    .entryRegs_o  (fifoRegs),
    .entryValid_o (fifoValid)
  );

  // Source selection, output staging and starvation tracking for this cycle.
  always_comb begin
    sel      = SEL_NONE;
    we_d     = 1'b0;
    reg_d    = reg_q;
    data_d   = data_q;
    aHold_d  = 1'b0;
    starve_d = '0;
    err_d    = err_q || (aHold_q && a_valid);

    if (aHold_q) begin
      sel = fifoEmpty ? SEL_NONE : SEL_B;
    end else if (a_valid) begin
      sel = SEL_A;
    end else if (!fifoEmpty) begin
      sel = SEL_B;
    end

    case (sel)
      SEL_A: begin
        we_d   = (a_reg != ZERO_REG);
        reg_d  = a_reg;
        data_d = a_data;
      end
      SEL_B: begin
        we_d   = (fifoHead.regAddr != ZERO_REG);
        reg_d  = fifoHead.regAddr;
        data_d = fifoHead.data;
      end
      default: we_d = 1'b0;
    endcase

    // Only an A win over waiting B work counts toward forcing a drain.
    if (sel == SEL_A && !fifoEmpty) begin
      if (starve_q == STARVE_LIMIT - 1'b1) begin
        aHold_d = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_comb begin
    pend1 = regHit(readReg1, reg_q, we_q);
    pend2 = regHit(readReg2, reg_q, we_q);
    for (int i = 0; i < DEPTH; i++) begin
      pend1 = pend1 || regHit(readReg1, fifoRegs[i], fifoValid[i]);
      pend2 = pend2 || regHit(readReg2, fifoRegs[i], fifoValid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      aHold_q  <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      reg_q    <= '0;
      data_q   <= '0;
    end else begin
      starve_q <= starve_d;
      aHold_q  <= aHold_d;
      err_q    <= err_d;
      we_q     <= we_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
    end
  end

  assign a_hold      = aHold_q;
  assign err         = err_q;
  assign RegWriteSig = we_q;
  assign writeReg    = reg_q;
  assign writeData   = data_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: a queue-based model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_write_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        a_hold;
  logic        err;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        pend1;
  logic        pend2;
  logic        RegWriteSig;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_valid     (a_valid),
    .a_reg       (a_reg),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_reg       (b_reg),
    .b_data      (b_data),
    .a_hold      (a_hold),
    .err         (err),
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .pend1       (pend1),
    .pend2       (pend2),
    .RegWriteSig (RegWriteSig),
    .writeReg    (writeReg),
    .writeData   (writeData)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the write port must show after each clock edge.
  bit          modelValid = 0;
  logic        expWe;
  logic [4:0]  expReg;
  logic [31:0] expData;
  logic        expHold;
  logic        expErr;
  int          starveM;
  ent_t        mq[$];

  always @(posedge clk) begin : modelUpdate
    ent_t head;
    bit   nonEmpty;
    bit   aWin;
    bit   drain;
    bit   take;
    if (reset) begin
      modelValid = 1;
      expWe   = 1'b0;
      expReg  = 5'd0;
      expData = 32'd0;
      expHold = 1'b0;
      expErr  = 1'b0;
      starveM = 0;
      mq.delete();
    end else if (modelValid) begin
      nonEmpty = (mq.size() > 0);
      take     = b_valid && (mq.size() < DEPTH);
      aWin     = 0;
      drain    = 0;
      if (expHold) begin
        if (a_valid) expErr = 1'b1;
        drain = nonEmpty;
      end else if (a_valid) begin
        aWin = 1;
      end else begin
        drain = nonEmpty;
      end
      if (aWin) begin
        expWe   = (a_reg != 5'd0);
        expReg  = a_reg;
        expData = a_data;
      end else if (drain) begin
        head    = mq.pop_front();
        expWe   = (head.r != 5'd0);
        expReg  = head.r;
        expData = head.d;
      end else begin
        expWe = 1'b0;
      end
      expHold = 1'b0;
      if (aWin && nonEmpty) begin
        starveM++;
        if (starveM == STARVE_MAX) begin
          expHold = 1'b1;
          starveM = 0;
        end
      end else begin
        starveM = 0;
      end
      if (take) mq.push_back('{r: b_reg, d: b_data});
    end
  end

  function automatic logic expPend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].r == r) return 1'b1;
    return expWe && (expReg == r);
  endfunction

  always @(negedge clk) begin
    #3;
    if (modelValid) begin
      checkOutput("RegWriteSig", {31'd0, RegWriteSig}, {31'd0, expWe});
      if (expWe) begin
        checkOutput("writeReg", {27'd0, writeReg}, {27'd0, expReg});
        checkOutput("writeData", writeData, expData);
      end
      checkOutput("a_hold", {31'd0, a_hold}, {31'd0, expHold});
      checkOutput("err", {31'd0, err}, {31'd0, expErr});
      checkOutput("b_ready", {31'd0, b_ready}, {31'd0, (mq.size() < DEPTH)});
      checkOutput("pend1", {31'd0, pend1}, {31'd0, expPend(readReg1)});
      checkOutput("pend2", {31'd0, pend2}, {31'd0, expPend(readReg2)});
    end
  end

  // Stimulus sources: each entry is offered until the DUT accepts it.
  ent_t aSrc[$];
  ent_t bSrc[$];
  bit   respectHold = 1;
  int   seenB[$];

  task automatic applyStimulus();
    bit   aTake;
    bit   bTake;
    ent_t tmp;
    a_valid = (aSrc.size() > 0) && !(respectHold && a_hold);
    if (aSrc.size() > 0) begin
      a_reg  = aSrc[0].r;
      a_data = aSrc[0].d;
    end
    b_valid = (bSrc.size() > 0);
    if (bSrc.size() > 0) begin
      b_reg  = bSrc[0].r;
      b_data = bSrc[0].d;
    end
    #1;
    aTake = a_valid;
    bTake = b_valid && b_ready;
    @(posedge clk);
    if (aTake) tmp = aSrc.pop_front();
    if (bTake) tmp = bSrc.pop_front();
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    a_valid  = 1'b0;
    a_reg    = 5'd0;
    a_data   = 32'd0;
    b_valid  = 1'b0;
    b_reg    = 5'd0;
    b_data   = 32'd0;
    readReg1 = 5'd0;
    readReg2 = 5'd0;
    @(negedge clk);
    @(negedge clk);

    // Reset state and idle
    checkOutput("rst RegWriteSig", {31'd0, RegWriteSig}, 32'd0);
    checkOutput("rst writeReg", {27'd0, writeReg}, 32'd0);
    checkOutput("rst writeData", writeData, 32'd0);
    checkOutput("rst a_hold", {31'd0, a_hold}, 32'd0);
    checkOutput("rst err", {31'd0, err}, 32'd0);
    checkOutput("rst b_ready", {31'd0, b_ready}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("idle RegWriteSig", {31'd0, RegWriteSig}, 32'd0);
    end

    // A alone
    aSrc.push_back('{r: 5'd20, d: 32'd50});
    applyStimulus();
    checkOutput("A RegWriteSig", {31'd0, RegWriteSig}, 32'd1);
    checkOutput("A writeReg", {27'd0, writeReg}, 32'd20);
    checkOutput("A writeData", writeData, 32'd50);
    applyStimulus();
    checkOutput("A after RegWriteSig", {31'd0, RegWriteSig}, 32'd0);

    // B alone, with hazard tracking on readReg1
    readReg1 = 5'd8;
    bSrc.push_back('{r: 5'd8, d: 32'hDEADBEEF});
    applyStimulus();
    checkOutput("B n+1 RegWriteSig", {31'd0, RegWriteSig}, 32'd0);
    checkOutput("B n+1 pend1", {31'd0, pend1}, 32'd1);
    applyStimulus();
    checkOutput("B n+2 RegWriteSig", {31'd0, RegWriteSig}, 32'd1);
    checkOutput("B n+2 writeReg", {27'd0, writeReg}, 32'd8);
    checkOutput("B n+2 writeData", writeData, 32'hDEADBEEF);
    checkOutput("B n+2 pend1", {31'd0, pend1}, 32'd1);
    applyStimulus();
    checkOutput("B n+3 pend1", {31'd0, pend1}, 32'd0);
    readReg1 = 5'd0;

    // Back-pressure and starvation
    for (int i = 1; i <= 8; i++) aSrc.push_back('{r: 5'(i), d: 32'(100 + i)});
    for (int i = 9; i <= 13; i++) bSrc.push_back('{r: 5'(i), d: 32'(200 + i)});
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("starve a_hold", {31'd0, a_hold}, 32'd1);
    checkOutput("full b_ready", {31'd0, b_ready}, 32'd0);
    checkOutput("starve writeReg", {27'd0, writeReg}, 32'd4);
    applyStimulus();
    checkOutput("hold drain writeReg", {27'd0, writeReg}, 32'd9);
    checkOutput("hold drain writeData", writeData, 32'd209);
    checkOutput("hold released", {31'd0, a_hold}, 32'd0);
    if (RegWriteSig) seenB.push_back(int'(writeReg));
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      if (RegWriteSig && writeReg >= 5'd9 && writeReg <= 5'd13) seenB.push_back(int'(writeReg));
    end
    checkOutput("B order count", 32'(seenB.size()), 32'd5);
    foreach (seenB[i]) checkOutput("B order", 32'(seenB[i]), 32'(9 + i));

    // Register $0 on both ports
    aSrc.push_back('{r: 5'd0, d: 32'd77});
    applyStimulus();
    checkOutput("A $0 RegWriteSig", {31'd0, RegWriteSig}, 32'd0);
    bSrc.push_back('{r: 5'd0, d: 32'd88});
    applyStimulus();
    applyStimulus();
    checkOutput("B $0 RegWriteSig", {31'd0, RegWriteSig}, 32'd0);

    // a_valid during a_hold sets sticky err
    respectHold = 0;
    bSrc.push_back('{r: 5'd5, d: 32'd55});
    for (int i = 21; i <= 25; i++) aSrc.push_back('{r: 5'(i), d: 32'(i)});
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("err set", {31'd0, err}, 32'd1);
    checkOutput("err drain writeReg", {27'd0, writeReg}, 32'd5);
    checkOutput("err drain writeData", writeData, 32'd55);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("err sticky", {31'd0, err}, 32'd1);
    end
    respectHold = 1;

    // Reset mid-operation drops queued B entries
    readReg1 = 5'd10;
    readReg2 = 5'd12;
    for (int i = 1; i <= 3; i++) aSrc.push_back('{r: 5'(i), d: 32'(i)});
    for (int i = 10; i <= 12; i++) bSrc.push_back('{r: 5'(i), d: 32'(300 + i)});
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("queued pend1", {31'd0, pend1}, 32'd1);
    checkOutput("queued pend2", {31'd0, pend2}, 32'd1);
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    checkOutput("post-rst b_ready", {31'd0, b_ready}, 32'd1);
    checkOutput("post-rst pend1", {31'd0, pend1}, 32'd0);
    checkOutput("post-rst pend2", {31'd0, pend2}, 32'd0);
    checkOutput("post-rst err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("dropped RegWriteSig", {31'd0, RegWriteSig}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
